// File: rtl/arbitro_escrita_banco.sv
// Round-robin write-port scheduler for the 32x32 register bank.
// Optional macro WB_FORWARD_EN adds same-cycle write-to-read forwarding.
module arbitro_escrita_banco #(
   parameter int NUM_REQ   = 3,
   parameter int REG0_FIXO = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [5*NUM_REQ-1:0]    req_addr,
   input  logic [32*NUM_REQ-1:0]   req_data,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic                    reserva_valid,
   input  logic [4:0]              reserva_addr,
`ifdef WB_FORWARD_EN
   input  logic [4:0]              endereco_leitura_1,
   input  logic [4:0]              endereco_leitura_2,
   input  logic [31:0]             Rs_banco,
   input  logic [31:0]             Rt_banco,
   output logic [31:0]             Rs_fwd,
   output logic [31:0]             Rt_fwd,
`endif
   output logic                    Reg_Write,
   output logic [4:0]              endereco_escrita,
   output logic [31:0]             escrever_dados,
   output logic [31:0]             ocupado
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PW-1:0]      ptr_q, ptr_d;
   logic               reg_write_q, reg_write_d;
   logic [4:0]         end_q, end_d;
   logic [31:0]        dados_q, dados_d;
   logic [31:0]        ocupado_q, ocupado_d;

   logic [NUM_REQ-1:0] gnt;
   logic [PW-1:0]      gnt_idx;
   logic               found;
   logic               xfer;
   logic [4:0]         acc_addr;
   logic [31:0]        acc_data;
   logic               drop;

   // Index wrap for values in 0..2*NUM_REQ-2.
   function automatic logic [PW-1:0] wrap(input int v);
      if (v >= NUM_REQ) return PW'(v - NUM_REQ);
      return PW'(v);
   endfunction

   // First valid requester at or after ptr, with wrap-around.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req_valid[wrap(int'(ptr_q) + k)]) begin
            found   = 1'b1;
            gnt_idx = wrap(int'(ptr_q) + k);
         end
      end
      gnt[gnt_idx] = found;
   end

   // Transfer decode, output stage and scoreboard next state.
   always_comb begin
      xfer        = found & ~reset;
      acc_addr    = req_addr[5*int'(gnt_idx) +: 5];
      acc_data    = req_data[32*int'(gnt_idx) +: 32];
      drop        = (REG0_FIXO == 1) && (acc_addr == 5'd0);
      ptr_d       = xfer ? wrap(int'(gnt_idx) + 1) : ptr_q;
      reg_write_d = xfer & ~drop;
      end_d       = xfer ? acc_addr : end_q;
      dados_d     = xfer ? acc_data : dados_q;
      ocupado_d   = ocupado_q;
      if (xfer) ocupado_d[acc_addr] = 1'b0;
      // A reservation in the same cycle is newer than the write, so it wins.
      if (reserva_valid) ocupado_d[reserva_addr] = 1'b1;
      if (REG0_FIXO == 1) ocupado_d[0] = 1'b0;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_q       <= '0;
         reg_write_q <= 1'b0;
         end_q       <= '0;
         dados_q     <= '0;
         ocupado_q   <= '0;
      end else begin
         ptr_q       <= ptr_d;
         reg_write_q <= reg_write_d;
         end_q       <= end_d;
         dados_q     <= dados_d;
         ocupado_q   <= ocupado_d;
      end
   end

   // Outputs are forced idle for the whole reset cycle.
   always_comb begin
      req_ready        = reset ? '0 : gnt;
      Reg_Write        = reg_write_q & ~reset;
      endereco_escrita = reset ? 5'd0 : end_q;
      escrever_dados   = reset ? 32'd0 : dados_q;
      ocupado          = reset ? 32'd0 : ocupado_q;
   end

`ifdef WB_FORWARD_EN
   logic fwd_ok;

   // Bypass the bank read when it targets the register being written now.
   always_comb begin
      fwd_ok = Reg_Write &&
               !((REG0_FIXO == 1) && (endereco_escrita == 5'd0));
      Rs_fwd = (fwd_ok && endereco_escrita == endereco_leitura_1) ?
               escrever_dados : Rs_banco;
      Rt_fwd = (fwd_ok && endereco_escrita == endereco_leitura_2) ?
               escrever_dados : Rt_banco;
   end
`endif

endmodule
